serv_ibus_rsp: RTL and testbench
================================

SERV_IBUS_RSP -- requirements
Module: serv_ibus_rsp

Interface
REQ-001 SHALL have parameter RESET_STRATEGY, default "MINI"; "MINI" resets control state only, "NONE" resets nothing.
REQ-002 SHALL have parameter MEM_AW, default 10; word-address width of the backing memory.
REQ-003 SHALL have one clock; reset is synchronous and active-high (clk, i_rst).
REQ-004 clk  input  1  clock; all state changes on its rising edge.
REQ-005 i_rst  input  1  synchronous active-high reset.
REQ-006 i_ibus_adr  input  32  fetch byte address from the core; bit 0 ignored, bit 1 set means halfword-aligned (compressed) fetch.
REQ-007 i_ibus_cyc  input  1  fetch request; held high until ack.
REQ-008 o_ibus_rdt  output  32  instruction word returned.
REQ-009 o_ibus_ack  output  1  one-cycle pulse; o_ibus_rdt valid in the same cycle.
REQ-010 i_inv  input  1  invalidate the word buffer.
REQ-011 o_mem_en  output  1  memory read strobe.
REQ-012 o_mem_adr  output  MEM_AW  memory word address.
REQ-013 i_mem_rdt  input  32  memory read data, valid the cycle after o_mem_en.

Function
REQ-014 SHALL implement states IDLE, WAIT1, WAIT2, ACK; o_ibus_ack = (state == ACK).
REQ-015 SHALL hold a one-entry word buffer {valid, tag[MEM_AW-1:0], data[31:0]}; a word hits when valid and tag matches.
REQ-016 Word addresses: lo = i_ibus_adr[MEM_AW+1:2]; hi = lo+1 modulo 2^MEM_AW (the last word wraps to word 0); higher address bits ignored.
REQ-017 Request accepted at cycle T when state is IDLE and i_ibus_cyc=1; the address is captured at T.
REQ-018 Aligned (adr[1]=0), lo hit: no memory read; ACK at T+1.
REQ-019 Aligned, lo miss: o_mem_en=1, o_mem_adr=lo combinationally at T; WAIT1 at T+1; ACK at T+2.
REQ-020 Misaligned, exactly one of lo/hi misses: the missing word is read at T; ACK at T+2.
REQ-021 Misaligned, both miss: lo read at T, hi read at T+1 (from WAIT1); WAIT2 at T+2; ACK at T+3.
REQ-022 Misaligned, both hit (only possible if lo==hi, i.e. MEM_AW=0): treat as aligned hit timing.
REQ-023 Aligned result SHALL be word(lo); misaligned result SHALL be {word(hi)[15:0], word(lo)[31:16]}.
REQ-024 o_ibus_rdt SHALL be registered, updated only on entry to ACK, and held otherwise.
REQ-025 Every memory read SHALL load the buffer with the data returned, tag set to that word address, and valid set to 1; after a two-read fetch the buffer holds hi.
REQ-026 ACK SHALL last one cycle and then return to IDLE; a request seen in the ACK cycle is not accepted until IDLE.
REQ-027 If i_ibus_cyc drops in WAIT1/WAIT2, outstanding reads SHALL complete and fill the buffer; no ack; return to IDLE.
REQ-028 i_inv SHALL clear the buffer valid bit; if it coincides with a buffer fill, valid ends at 0, and the in-flight fetch still returns the fetched data.
REQ-029 o_mem_en SHALL be 0 except in the issuing cycles defined above; at most one read per cycle.

Reset
REQ-030 i_rst SHALL force state=IDLE, o_ibus_ack=0, buffer valid=0 on the next edge, including mid-transaction; no ack follows.
REQ-031 Under "MINI", o_ibus_rdt, the buffer tag and the buffer data SHALL NOT be reset.
REQ-032 Under "NONE", the reset port SHALL be ignored, and the state and buffer valid bit SHALL have initial values IDLE and 0.

Structure
REQ-033 SHALL keep the state encoding as local constants; no shared package is needed.
REQ-034 SHALL be flat, with no sub-module; the memory is external.

Verification
REQ-035 Aligned fetch 0x100, buffer empty, memory word 0x40=0x00A00093 -> read adr 0x40 at T, ack T+2, rdt=0x00A00093.
REQ-036 Misaligned fetch 0x102, word 0x40=0xAAAA1111, word 0x41=0x2222BBBB, buffer empty -> reads 0x40, then 0x41, ack T+3, rdt=0xBBBBAAAA, buffer tag=0x41.
REQ-037 Follow REQ-036 with a fetch of 0x106 -> single read 0x42, ack T+2; then aligned fetch 0x108 -> hits the buffer (tag 0x42), no read, ack T+1.
REQ-038 Misaligned fetch at byte 0xFFE (MEM_AW=10) -> reads 0x3FF then wraps to 0x000; rdt = {word0[15:0], word3FF[31:16]}.
REQ-039 Drop i_ibus_cyc in WAIT1, or pulse i_rst in WAIT2 -> no ack; next fetch accepted from IDLE; after reset, the buffer misses.
REQ-040 i_inv asserted during a fill cycle -> current fetch acks correctly; an immediate refetch of the same word misses and reads memory.

Source files
------------

// File: rtl/serv_ibus_rsp_pkg.sv
// Shared widths and the halfword-merge helper for the instruction fetch responder.
package serv_ibus_rsp_pkg;

  localparam int IBUS_DW = 32;

  // A halfword-aligned fetch takes the upper half of the low word and the lower half of the high word.
  function automatic logic [IBUS_DW-1:0] merge_half(input logic [IBUS_DW-1:0] hi_w,
                                                   input logic [IBUS_DW-1:0] lo_w);
    return {hi_w[15:0], lo_w[31:16]};
  endfunction

endpackage

// File: rtl/serv_ibus_rsp_if.sv
// Core-side instruction fetch bus: address/request from the core, data/ack back to it.
interface serv_ibus_rsp_if;

  logic [serv_ibus_rsp_pkg::IBUS_DW-1:0] i_ibus_adr;
  logic                                  i_ibus_cyc;
  logic [serv_ibus_rsp_pkg::IBUS_DW-1:0] o_ibus_rdt;
  logic                                  o_ibus_ack;

  modport master (output i_ibus_adr, output i_ibus_cyc, input o_ibus_rdt, input o_ibus_ack);
  modport slave  (input i_ibus_adr, input i_ibus_cyc, output o_ibus_rdt, output o_ibus_ack);

endinterface

// File: rtl/serv_ibus_rsp.sv
// Instruction fetch responder with a one-word buffer; halfword-aligned fetches may need two memory reads.
// Ack 1 cycle after a hit, 2 after one read, 3 after two; the core holds cyc until ack.
module serv_ibus_rsp
  import serv_ibus_rsp_pkg::*;
#(
  parameter     RESET_STRATEGY = "MINI",
  parameter int MEM_AW         = 10
) (
  input  logic              clk,
  input  logic              i_rst,
  serv_ibus_rsp_if.slave    ibus,
  input  logic              i_inv,
  output logic              o_mem_en,
  output logic [MEM_AW-1:0] o_mem_adr,
  input  logic [31:0]       i_mem_rdt
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WAIT1 = 2'd1;
  localparam logic [1:0] WAIT2 = 2'd2;
  localparam logic [1:0] ACK   = 2'd3;

  localparam bit USE_RST = (RESET_STRATEGY != "NONE");

  logic              rst;
  logic [1:0]        state = IDLE;
  logic [1:0]        state_nxt;
  logic              buf_vld = 1'b0;
  logic [MEM_AW-1:0] buf_tag;
  logic [31:0]       buf_dat;
  logic [31:0]       rdt;

  logic [MEM_AW-1:0] lo, hi, lo_q, hi_q, fill_tag;
  logic              mis, lo_hit, hi_hit, miss, accept, fill, two_q, rd_hi_q, mis_q;
  logic [31:0]       hit_res, rd_res;
  logic              unused;

  assign rst    = USE_RST && i_rst;
  assign unused = ^{ibus.i_ibus_adr[31:MEM_AW+2], ibus.i_ibus_adr[0]};

  assign lo     = ibus.i_ibus_adr[MEM_AW+1:2];
  assign hi     = lo + MEM_AW'(1);
  assign mis    = ibus.i_ibus_adr[1];
  assign lo_hit = buf_vld && (buf_tag == lo);
  assign hi_hit = buf_vld && (buf_tag == hi);
  assign miss   = !lo_hit || (mis && !hi_hit);
  assign accept = (state == IDLE) && ibus.i_ibus_cyc;
  assign fill   = (state == WAIT1) || (state == WAIT2);

  // The first read goes to whichever word is missing, low word first.
  assign o_mem_en  = (accept && miss) || ((state == WAIT1) && two_q && ibus.i_ibus_cyc);
  assign o_mem_adr = (state == IDLE) ? (lo_hit ? hi : lo) : hi_q;
  assign fill_tag  = ((state == WAIT2) || rd_hi_q) ? hi_q : lo_q;

  assign hit_res = mis ? merge_half(buf_dat, buf_dat) : buf_dat;
  // While a read returns, buf_dat still holds the other word of the pair.
  always_comb begin
    rd_res = i_mem_rdt;
    if (state == WAIT2)
      rd_res = merge_half(i_mem_rdt, buf_dat);
    else if (mis_q)
      rd_res = rd_hi_q ? merge_half(i_mem_rdt, buf_dat) : merge_half(buf_dat, i_mem_rdt);
  end

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = accept ? (miss ? WAIT1 : ACK) : IDLE;
      WAIT1:   state_nxt = !ibus.i_ibus_cyc ? IDLE : (two_q ? WAIT2 : ACK);
      WAIT2:   state_nxt = ibus.i_ibus_cyc ? ACK : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      buf_vld <= 1'b0;
    end else begin
      state   <= state_nxt;
      buf_vld <= !i_inv && (fill || buf_vld);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      mis_q   <= mis;
      two_q   <= mis && !lo_hit && !hi_hit;
      rd_hi_q <= lo_hit;
      lo_q    <= lo;
      hi_q    <= hi;
    end
    if (fill) begin
      buf_tag <= fill_tag;
      buf_dat <= i_mem_rdt;
    end
    if (!rst && (state_nxt == ACK))
      rdt <= (state == IDLE) ? hit_res : rd_res;
  end

  assign ibus.o_ibus_rdt = rdt;
  assign ibus.o_ibus_ack = (state == ACK);

endmodule

// File: tb/tb_serv_ibus_rsp.sv
// Directed bench for serv_ibus_rsp with a behavioural one-cycle-latency memory.
module tb_serv_ibus_rsp;
  import serv_ibus_rsp_pkg::*;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_inv = 1'b0;
  logic        o_mem_en;
  logic [9:0]  o_mem_adr;
  logic [31:0] i_mem_rdt;
  logic [31:0] mem [0:1023];
  logic [9:0]  rd_q [$];
  int          checks = 0;
  int          errors = 0;

  serv_ibus_rsp_if ibus ();

  serv_ibus_rsp #(.RESET_STRATEGY("MINI"), .MEM_AW(10)) dut (
    .clk       (clk),
    .i_rst     (i_rst),
    .ibus      (ibus),
    .i_inv     (i_inv),
    .o_mem_en  (o_mem_en),
    .o_mem_adr (o_mem_adr),
    .i_mem_rdt (i_mem_rdt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (o_mem_en) begin
      rd_q.push_back(o_mem_adr);
      i_mem_rdt <= mem[o_mem_adr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issues one fetch and checks first-cycle strobe, ack latency, data and the reads performed.
  task automatic fetch(input string tag, input logic [31:0] a, input logic [31:0] exp_rdt,
                       input int exp_lat, input int exp_nrd, input logic [9:0] exp_a0,
                       input logic [9:0] exp_a1, input bit inv_w1);
    int lat;
    bit got;
    @(negedge clk);
    ibus.i_ibus_adr = a;
    ibus.i_ibus_cyc = 1'b1;
    rd_q.delete();
    #1;
    chk({tag, ".en_T"}, 32'(o_mem_en), 32'(exp_nrd > 0));
    if (exp_nrd > 0) chk({tag, ".adr_T"}, 32'(o_mem_adr), 32'(exp_a0));
    lat = 0;
    got = 1'b0;
    while (!got && lat < 8) begin
      @(negedge clk);
      lat++;
      i_inv = inv_w1 && (lat == 1);
      if (ibus.o_ibus_ack) got = 1'b1;
    end
    i_inv = 1'b0;
    chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".rdt"}, ibus.o_ibus_rdt, exp_rdt);
    chk({tag, ".nrd"}, 32'(rd_q.size()), 32'(exp_nrd));
    if (exp_nrd == 2 && rd_q.size() == 2) chk({tag, ".adr_hi"}, 32'(rd_q[1]), 32'(exp_a1));
    ibus.i_ibus_cyc = 1'b0;
  endtask

  task automatic no_ack(input string tag, input int cycles);
    int acks = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (ibus.o_ibus_ack) acks++;
    end
    chk(tag, 32'(acks), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    ibus.i_ibus_adr = 32'h0;
    ibus.i_ibus_cyc = 1'b0;
    mem[10'h040] = 32'h00A00093;
    mem[10'h041] = 32'h2222BBBB;
    mem[10'h042] = 32'h4444CCCC;
    mem[10'h3FF] = 32'h12345678;
    mem[10'h000] = 32'h9ABCDEF0;
    mem[10'h080] = 32'h13579BDF;
    mem[10'h0C0] = 32'h11112222;
    mem[10'h0C1] = 32'h33334444;
    mem[10'h100] = 32'hCAFEF00D;

    repeat (2) @(negedge clk);
    chk("rst.ack", 32'(ibus.o_ibus_ack), 32'd0);
    chk("rst.en", 32'(o_mem_en), 32'd0);
    i_rst = 1'b0;

    fetch("aligned_miss", 32'h100, 32'h00A00093, 2, 1, 10'h040, 10'h0, 1'b0);

    @(negedge clk);
    i_inv = 1'b1;
    @(negedge clk);
    i_inv = 1'b0;
    mem[10'h040] = 32'hAAAA1111;
    fetch("mis_both", 32'h102, 32'hBBBBAAAA, 3, 2, 10'h040, 10'h041, 1'b0);
    fetch("mis_hi_miss", 32'h106, 32'hCCCC2222, 2, 1, 10'h042, 10'h0, 1'b0);
    fetch("aligned_hit", 32'h108, 32'h4444CCCC, 1, 0, 10'h0, 10'h0, 1'b0);

    @(negedge clk);
    chk("hold.ack", 32'(ibus.o_ibus_ack), 32'd0);
    chk("hold.rdt", ibus.o_ibus_rdt, 32'h4444CCCC);

    fetch("wrap", 32'hFFE, 32'hDEF01234, 3, 2, 10'h3FF, 10'h000, 1'b0);

    // Request withdrawn while the read is in flight: the word still lands in the buffer.
    @(negedge clk);
    ibus.i_ibus_adr = 32'h200;
    ibus.i_ibus_cyc = 1'b1;
    @(negedge clk);
    ibus.i_ibus_cyc = 1'b0;
    no_ack("drop.noack", 4);
    fetch("drop.refetch", 32'h200, 32'h13579BDF, 1, 0, 10'h0, 10'h0, 1'b0);

    // Reset while waiting on the second read of a halfword-aligned fetch.
    @(negedge clk);
    ibus.i_ibus_adr = 32'h302;
    ibus.i_ibus_cyc = 1'b1;
    @(negedge clk);
    @(negedge clk);
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    ibus.i_ibus_cyc = 1'b0;
    chk("rst_mid.ack", 32'(ibus.o_ibus_ack), 32'd0);
    no_ack("rst_mid.noack", 3);
    fetch("rst_mid.refetch", 32'h304, 32'h33334444, 2, 1, 10'h0C1, 10'h0, 1'b0);

    fetch("inv_fill", 32'h400, 32'hCAFEF00D, 2, 1, 10'h100, 10'h0, 1'b1);
    fetch("inv_refetch", 32'h400, 32'hCAFEF00D, 2, 1, 10'h100, 10'h0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
